max_burst_sched: RTL and testbench

Sequencing controller for the shared max/compare-select datapath. It accepts a burst of W-bit operands over a valid/ready stream and feeds each operand against the running maximum through an external combinational compare unit. That unit can be the exact comparator or a BLASYS-approximated variant. When the burst ends, the block returns the burst maximum, its position and the element count. It sits between the operand producer and the result consumer, and owns the only path into the compare unit.

---
 rtl/max_burst_sched.sv | 112 +++++++++++
 tb/tb_max_burst_sched.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/max_burst_sched.sv
// Burst maximum sequencer: streams operands against a running maximum through an
// external compare unit and reports max, position and saturating count per burst.
module max_burst_sched #(
  parameter int W    = 8,
  parameter int IDXW = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [W-1:0]    in_data,
  input  logic            in_last,
  output logic [W-1:0]    cmp_a,
  output logic [W-1:0]    cmp_b,
  input  logic            cmp_gt,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [W-1:0]    out_max,
  output logic [IDXW-1:0] out_idx,
  output logic [IDXW-1:0] out_count,
  output logic            out_ovf
);

  typedef enum logic [1:0] {IDLE, ACC, OUT} state_t;

  localparam logic [IDXW-1:0] CNT_MAX = '1;

  state_t          state;
  logic [W-1:0]    max_q;
  logic [IDXW-1:0] idx_q;
  logic [IDXW-1:0] cnt_q;
  logic            ovf_q;
  logic            accept;
  logic            handoff;
  logic            cnt_sat;

  assign accept  = in_valid & in_ready;
  assign handoff = out_valid & out_ready;
  assign cnt_sat = (cnt_q == CNT_MAX);

  // The compare unit always sees the running max against the operand on the bus.
  assign cmp_a = max_q;
  assign cmp_b = in_data;

  assign out_max   = max_q;
  assign out_idx   = idx_q;
  assign out_count = cnt_q;
  assign out_ovf   = ovf_q;

  // in_ready/out_valid are registered alongside the state so they never glitch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      max_q     <= '0;
      idx_q     <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            max_q <= in_data;
            idx_q <= '0;
            cnt_q <= IDXW'(1);
            ovf_q <= 1'b0;
            if (in_last) begin
              state     <= OUT;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
            end else begin
              state <= ACC;
            end
          end
        end
        ACC: begin
          if (accept) begin
            // Selection comes only from cmp_gt; idx takes the already-saturated count.
            if (cmp_gt) begin
              max_q <= in_data;
              idx_q <= cnt_q;
            end
            if (cnt_sat) begin
              ovf_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + IDXW'(1);
            end
            if (in_last) begin
              state     <= OUT;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
            end
          end
        end
        OUT: begin
          if (handoff) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_max_burst_sched.sv
// Bench for max_burst_sched: a wide-count and a narrow-count instance share one
// stimulus stream and are checked against a queue-based burst model.
module tb_max_burst_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_last;
  logic        out_ready;
  logic        force_gt;

  logic        a_in_ready, a_out_valid, a_cmp_gt, a_out_ovf;
  logic [7:0]  a_cmp_a, a_cmp_b, a_out_max, a_out_idx, a_out_count;

  logic        b_in_ready, b_out_valid, b_cmp_gt, b_out_ovf;
  logic [7:0]  b_cmp_a, b_cmp_b, b_out_max;
  logic [1:0]  b_out_idx, b_out_count;

  int checks = 0;
  int errors = 0;
  logic [7:0] burst_q[$];

  always #5 clk = ~clk;

  // Behavioural compare unit: exact strict greater-than, or a stub forcing "greater".
  assign a_cmp_gt = force_gt ? 1'b1 : (a_cmp_b > a_cmp_a);
  assign b_cmp_gt = force_gt ? 1'b1 : (b_cmp_b > b_cmp_a);

  max_burst_sched #(.W(8), .IDXW(8)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_data(in_data), .in_last(in_last), .cmp_a(a_cmp_a), .cmp_b(a_cmp_b),
    .cmp_gt(a_cmp_gt), .out_valid(a_out_valid), .out_ready(out_ready),
    .out_max(a_out_max), .out_idx(a_out_idx), .out_count(a_out_count),
    .out_ovf(a_out_ovf)
  );

  max_burst_sched #(.W(8), .IDXW(2)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_data(in_data), .in_last(in_last), .cmp_a(b_cmp_a), .cmp_b(b_cmp_b),
    .cmp_gt(b_cmp_gt), .out_valid(b_out_valid), .out_ready(out_ready),
    .out_max(b_out_max), .out_idx(b_out_idx), .out_count(b_out_count),
    .out_ovf(b_out_ovf)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Burst result from the rules: first strict maximum (or last element when the
  // compare unit always says greater), count/index clipped at the counter ceiling.
  task automatic model(input int sat, output logic [7:0] emax, output int eidx,
                       output int ecount, output bit eovf);
    int n;
    int pos;
    n = burst_q.size();
    pos = 0;
    emax = burst_q[0];
    if (force_gt) begin
      pos = n - 1;
      emax = burst_q[n-1];
    end else begin
      for (int i = 1; i < n; i++) begin
        if (burst_q[i] > emax) begin
          emax = burst_q[i];
          pos = i;
        end
      end
    end
    ecount = (n < sat) ? n : sat;
    eidx   = (pos < sat) ? pos : sat;
    eovf   = (n > sat);
  endtask

  // Called on a falling edge; returns on the falling edge after the operand is taken.
  task automatic applyStimulus(input logic [7:0] d, input logic last);
    int waited;
    waited = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    while (!a_in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 50) chk("accept_timeout", 32'(a_in_ready), 32'd1);
    chk("ready_match", 32'(b_in_ready), 32'(a_in_ready));
    @(negedge clk);
    burst_q.push_back(d);
    in_valid = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input int hold);
    logic [7:0] emax;
    int eidx, ecount;
    bit eovf;
    int waited;
    chk({tag, "_latency"}, 32'(a_out_valid), 32'd1);
    waited = 0;
    while (!a_out_valid && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    model(255, emax, eidx, ecount, eovf);
    out_ready = 1'b0;
    for (int c = 0; c <= hold; c++) begin
      chk({tag, "_a_max"}, 32'(a_out_max), 32'(emax));
      chk({tag, "_a_idx"}, 32'(a_out_idx), 32'(eidx));
      chk({tag, "_a_cnt"}, 32'(a_out_count), 32'(ecount));
      chk({tag, "_a_ovf"}, 32'(a_out_ovf), 32'(eovf));
      chk({tag, "_a_cmpa"}, 32'(a_cmp_a), 32'(emax));
      chk({tag, "_a_inrdy"}, 32'(a_in_ready), 32'd0);
      if (c < hold) @(negedge clk);
    end
    model(3, emax, eidx, ecount, eovf);
    chk({tag, "_b_valid"}, 32'(b_out_valid), 32'd1);
    chk({tag, "_b_max"}, 32'(b_out_max), 32'(emax));
    chk({tag, "_b_idx"}, 32'(b_out_idx), 32'(eidx));
    chk({tag, "_b_cnt"}, 32'(b_out_count), 32'(ecount));
    chk({tag, "_b_ovf"}, 32'(b_out_ovf), 32'(eovf));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_post_valid"}, 32'(a_out_valid), 32'd0);
    chk({tag, "_post_ready"}, 32'(a_in_ready), 32'd1);
    burst_q.delete();
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int n, gap;
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = 8'h00;
    in_last = 1'b0;
    out_ready = 1'b0;
    force_gt = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 32'(a_in_ready), 32'd1);
    chk("rst_out_valid", 32'(a_out_valid), 32'd0);
    chk("rst_out_max", 32'(a_out_max), 32'd0);
    chk("rst_out_idx", 32'(a_out_idx), 32'd0);
    chk("rst_out_count", 32'(a_out_count), 32'd0);
    chk("rst_out_ovf", 32'(a_out_ovf), 32'd0);
    chk("rst_cmp_a", 32'(a_cmp_a), 32'd0);

    // Tie on 9: the earlier position must win.
    applyStimulus(8'd3, 1'b0);
    applyStimulus(8'd9, 1'b0);
    applyStimulus(8'd4, 1'b0);
    applyStimulus(8'd9, 1'b1);
    chk("tie_idx_const", 32'(a_out_idx), 32'd1);
    chk("tie_cnt_const", 32'(a_out_count), 32'd4);
    checkOutput("tie", 1);

    applyStimulus(8'hA5, 1'b1);
    chk("single_max_const", 32'(a_out_max), 32'hA5);
    checkOutput("single", 0);

    // Result held for five cycles while the next burst's first operand waits.
    applyStimulus(8'd1, 1'b0);
    applyStimulus(8'd2, 1'b0);
    applyStimulus(8'd3, 1'b1);
    in_valid = 1'b1;
    in_data = 8'd4;
    in_last = 1'b0;
    checkOutput("held", 5);
    applyStimulus(8'd4, 1'b0);
    applyStimulus(8'd8, 1'b1);
    checkOutput("waited", 0);

    force_gt = 1'b1;
    applyStimulus(8'd5, 1'b0);
    applyStimulus(8'd9, 1'b0);
    applyStimulus(8'd1, 1'b0);
    applyStimulus(8'd3, 1'b1);
    chk("stub_max_const", 32'(a_out_max), 32'd3);
    chk("stub_idx_const", 32'(a_out_idx), 32'd3);
    checkOutput("stub", 0);
    force_gt = 1'b0;

    applyStimulus(8'd1, 1'b0);
    applyStimulus(8'd2, 1'b0);
    applyStimulus(8'd3, 1'b0);
    applyStimulus(8'd4, 1'b0);
    applyStimulus(8'd9, 1'b1);
    chk("sat_cnt_const", 32'(b_out_count), 32'd3);
    chk("sat_ovf_const", 32'(b_out_ovf), 32'd1);
    chk("sat_idx_const", 32'(b_out_idx), 32'd3);
    checkOutput("sat", 0);

    // Reset in the middle of a burst discards it without any result.
    applyStimulus(8'd50, 1'b0);
    applyStimulus(8'd60, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    burst_q.delete();
    for (int c = 0; c < 3; c++) begin
      chk("midrst_no_valid", 32'(a_out_valid), 32'd0);
      @(negedge clk);
    end
    chk("midrst_max", 32'(a_out_max), 32'd0);
    chk("midrst_cnt", 32'(a_out_count), 32'd0);
    applyStimulus(8'd7, 1'b0);
    applyStimulus(8'd2, 1'b1);
    chk("after_rst_max_const", 32'(a_out_max), 32'd7);
    checkOutput("after_rst", 0);

    for (int b = 0; b < 25; b++) begin
      force_gt = ($urandom_range(0, 3) == 0);
      n = $urandom_range(1, 8);
      for (int e = 0; e < n; e++) begin
        gap = $urandom_range(0, 2);
        in_valid = 1'b0;
        for (int g = 0; g < gap; g++) begin
          in_data = 8'($urandom);
          in_last = 1'($urandom);
          @(negedge clk);
        end
        applyStimulus(8'($urandom_range(0, 15) * 17), (e == n - 1));
      end
      checkOutput("rand", $urandom_range(0, 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
